// File: rtl/state_controller_wide.sv
// Save/restore controller moving a core's architectural state between its
// LANE_WIDTH-wide scan chain and memory, one INTERFACE_WIDTH word at a time.
module state_controller_wide #(
    parameter int INTERFACE_WIDTH      = 32,
    parameter int INTERFACE_ADDR_WIDTH = 32,
    parameter int STATE_BITS           = 2853,
    parameter int LANE_WIDTH           = 1
) (
    input  logic                            iClk,
    input  logic                            iReset,
    input  logic                            iStall,
    input  logic                            iStateReadRequest,
    input  logic                            iStateWriteRequest,
    input  logic                            iStateSwapRequest,
    input  logic                            iDisableShiftIn,
    input  logic                            iDisableShiftOut,
    input  logic                            iDisableExec,
    input  logic [INTERFACE_ADDR_WIDTH-1:0] iReadAddress,
    input  logic [INTERFACE_ADDR_WIDTH-1:0] iWriteAddress,
    output logic                            oStateSwitchHalt,
    output logic                            oBusy,
    output logic                            oDone,
    output logic                            oError,
    input  logic [LANE_WIDTH-1:0]           iStateDataOut,
    output logic [LANE_WIDTH-1:0]           oStateDataIn,
    output logic                            oStateShift,
    output logic                            oStateNewIn,
    output logic                            oStateOldOut,
    output logic                            oStateMemReadRequest,
    output logic                            oStateMemWriteRequest,
    output logic [INTERFACE_ADDR_WIDTH-1:0] oStateMemAddress,
    output logic [INTERFACE_WIDTH-1:0]      oStateMemWriteData,
    input  logic [INTERFACE_WIDTH-1:0]      iStateMemReadData,
    input  logic                            iWriteAccept,
    input  logic                            iReadValid
);
    localparam int NUM_WORDS       = (STATE_BITS + INTERFACE_WIDTH - 1) / INTERFACE_WIDTH;
    localparam int SHIFTS_PER_WORD = INTERFACE_WIDTH / LANE_WIDTH;
    localparam int LAST_SHIFTS     = (STATE_BITS - (NUM_WORDS - 1) * INTERFACE_WIDTH) / LANE_WIDTH;
    localparam int BYTES_PER_WORD  = INTERFACE_WIDTH / 8;
    localparam int WORD_IDX_W      = $clog2(NUM_WORDS + 1);
    localparam int SHIFT_CNT_W     = $clog2(SHIFTS_PER_WORD + 1);

    typedef enum logic [2:0] {IDLE, SHIFTIN, WAITMEM, SETSIG, SHIFTOUT} stateT;

    stateT                           state, nextState;
    logic [WORD_IDX_W-1:0]           wordIdx;
    logic [SHIFT_CNT_W-1:0]          shiftCnt;
    logic                            memPending;
    logic [INTERFACE_WIDTH-1:0]      buffer;
    logic [2:0]                      reqPrev;
    logic [INTERFACE_ADDR_WIDTH-1:0] readBase, writeBase;
    logic                            disShiftIn, disShiftOut, disExec;
    logic                            opRestore, opSave;
    logic                            doneReg, errorReg;

    logic [2:0]                      reqNow, reqRise;
    logic                            multiRise, acceptReq, startRestore, startSave;
    logic                            lastWord, lastShift, writeDone;
    logic [SHIFT_CNT_W-1:0]          wordShifts;
    int                              laneBase;
    logic [INTERFACE_ADDR_WIDTH-1:0] wordOffset;

    assign reqNow       = {iStateSwapRequest, iStateWriteRequest, iStateReadRequest};
    assign reqRise      = reqNow & ~reqPrev;
    assign multiRise    = (reqRise[0] & reqRise[1]) | (reqRise[0] & reqRise[2]) | (reqRise[1] & reqRise[2]);
    assign acceptReq    = (|reqRise) & ~multiRise;
    assign startRestore = reqRise[1] | reqRise[2];
    assign startSave    = reqRise[0] | reqRise[2];

    assign lastWord   = (wordIdx == WORD_IDX_W'(NUM_WORDS - 1));
    assign wordShifts = lastWord ? SHIFT_CNT_W'(LAST_SHIFTS) : SHIFT_CNT_W'(SHIFTS_PER_WORD);
    assign lastShift  = (shiftCnt == wordShifts - 1'b1);
    assign writeDone  = (state == SHIFTOUT) && memPending && iWriteAccept;
    assign laneBase   = int'(shiftCnt) * LANE_WIDTH;
    assign wordOffset = INTERFACE_ADDR_WIDTH'(wordIdx) * INTERFACE_ADDR_WIDTH'(BYTES_PER_WORD);

    // Within a shift phase memPending is 0; it rises once the word is ready for memory.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     if (acceptReq) begin
                          if (startRestore) nextState = iDisableShiftIn ? WAITMEM : SHIFTIN;
                          else              nextState = SETSIG;
                      end
            SHIFTIN:  if (!memPending && lastShift && lastWord) nextState = WAITMEM;
            WAITMEM:  if (!iStall) nextState = SETSIG;
            SETSIG:   nextState = (opSave && !disShiftOut) ? SHIFTOUT : IDLE;
            SHIFTOUT: if (writeDone && lastWord) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state       <= IDLE;
            wordIdx     <= '0;
            shiftCnt    <= '0;
            memPending  <= 1'b0;
            // NOTE: the word buffer is an ordinary register, so it is reset with the FSM.
            buffer      <= '0;
            reqPrev     <= '0;
            readBase    <= '0;
            writeBase   <= '0;
            disShiftIn  <= 1'b0;
            disShiftOut <= 1'b0;
            disExec     <= 1'b0;
            opRestore   <= 1'b0;
            opSave      <= 1'b0;
            doneReg     <= 1'b0;
            errorReg    <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every branch sees the pre-edge register values.
            state    <= nextState;
            doneReg  <= 1'b0;
            errorReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    reqPrev  <= reqNow;
                    errorReg <= multiRise;
                    if (acceptReq) begin
                        readBase    <= iReadAddress;
                        writeBase   <= iWriteAddress;
                        disShiftIn  <= iDisableShiftIn;
                        disShiftOut <= iDisableShiftOut;
                        disExec     <= iDisableExec;
                        opRestore   <= startRestore;
                        opSave      <= startSave;
                        wordIdx     <= '0;
                        shiftCnt    <= '0;
                        memPending  <= 1'b1;
                    end
                end
                SHIFTIN: begin
                    if (memPending) begin
                        if (iReadValid) begin
                            buffer     <= iStateMemReadData;
                            memPending <= 1'b0;
                            shiftCnt   <= '0;
                        end
                    end else if (lastShift) begin
                        shiftCnt   <= '0;
                        memPending <= 1'b1;
                        wordIdx    <= wordIdx + 1'b1;
                    end else begin
                        shiftCnt <= shiftCnt + 1'b1;
                    end
                end
                SETSIG: begin
                    doneReg    <= (nextState == IDLE);
                    wordIdx    <= '0;
                    shiftCnt   <= '0;
                    memPending <= 1'b0;
                    buffer     <= '0;
                end
                SHIFTOUT: begin
                    if (!memPending) begin
                        buffer[laneBase +: LANE_WIDTH] <= iStateDataOut;
                        if (lastShift) memPending <= 1'b1;
                        else           shiftCnt   <= shiftCnt + 1'b1;
                    end else if (iWriteAccept) begin
                        doneReg    <= lastWord;
                        memPending <= 1'b0;
                        shiftCnt   <= '0;
                        buffer     <= '0;
                        wordIdx    <= wordIdx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        oStateShift           = (state == SHIFTIN || state == SHIFTOUT) && !memPending;
        oStateMemReadRequest  = (state == SHIFTIN) && memPending;
        oStateMemWriteRequest = (state == SHIFTOUT) && memPending;
        oStateDataIn          = '1;
        oStateMemAddress      = '0;
        oStateMemWriteData    = '0;
        if (state == SHIFTIN && !memPending) oStateDataIn = buffer[laneBase +: LANE_WIDTH];
        if (oStateMemReadRequest)  oStateMemAddress = readBase + wordOffset;
        if (oStateMemWriteRequest) begin
            oStateMemAddress   = writeBase + wordOffset;
            oStateMemWriteData = buffer;
        end
        oStateNewIn      = (state == SETSIG) && opRestore && !disExec;
        oStateOldOut     = (state == SETSIG) && opSave && !disExec;
        oStateSwitchHalt = (state == WAITMEM) || (opRestore && (state == SETSIG || state == SHIFTOUT));
        oBusy            = (state != IDLE);
        oDone            = doneReg;
        oError           = errorReg;
    end
endmodule

// File: tb/tb_state_controller_wide.sv
// Directed bench: a 2-bit-lane, 70-bit-chain instance covers save/restore/swap,
// request errors and mid-sequence reset; an 8-bit-lane instance covers address wrap.
`timescale 1ns/1ps
module tb_state_controller_wide;
    logic iClk = 1'b0;
    logic iReset;
    always #5 iClk = ~iClk;

    // Instance A: IW=32, LW=2, STATE_BITS=70
    logic        aStall, aRdReq, aWrReq, aSwReq, aDisIn, aDisOut, aDisExec;
    logic [31:0] aRdAddr, aWrAddr, aMemAddr, aMemWData, aMemRData;
    logic        aHalt, aBusy, aDone, aError, aShift, aNewIn, aOldOut, aMemRd, aMemWr;
    logic        aWrAccept, aRdValid;
    logic [1:0]  aDataOut, aDataIn;

    // Instance B: IW=32, LW=8, STATE_BITS=64
    logic        bStall, bRdReq, bWrReq, bSwReq, bDisIn, bDisOut, bDisExec;
    logic [31:0] bRdAddr, bWrAddr, bMemAddr, bMemWData, bMemRData;
    logic        bHalt, bBusy, bDone, bError, bShift, bNewIn, bOldOut, bMemRd, bMemWr;
    logic        bWrAccept, bRdValid;
    logic [7:0]  bDataOut, bDataIn;

    state_controller_wide #(.INTERFACE_WIDTH(32), .INTERFACE_ADDR_WIDTH(32),
                            .STATE_BITS(70), .LANE_WIDTH(2)) dutA (
        .iClk(iClk), .iReset(iReset), .iStall(aStall),
        .iStateReadRequest(aRdReq), .iStateWriteRequest(aWrReq), .iStateSwapRequest(aSwReq),
        .iDisableShiftIn(aDisIn), .iDisableShiftOut(aDisOut), .iDisableExec(aDisExec),
        .iReadAddress(aRdAddr), .iWriteAddress(aWrAddr),
        .oStateSwitchHalt(aHalt), .oBusy(aBusy), .oDone(aDone), .oError(aError),
        .iStateDataOut(aDataOut), .oStateDataIn(aDataIn), .oStateShift(aShift),
        .oStateNewIn(aNewIn), .oStateOldOut(aOldOut),
        .oStateMemReadRequest(aMemRd), .oStateMemWriteRequest(aMemWr),
        .oStateMemAddress(aMemAddr), .oStateMemWriteData(aMemWData),
        .iStateMemReadData(aMemRData), .iWriteAccept(aWrAccept), .iReadValid(aRdValid));

    state_controller_wide #(.INTERFACE_WIDTH(32), .INTERFACE_ADDR_WIDTH(32),
                            .STATE_BITS(64), .LANE_WIDTH(8)) dutB (
        .iClk(iClk), .iReset(iReset), .iStall(bStall),
        .iStateReadRequest(bRdReq), .iStateWriteRequest(bWrReq), .iStateSwapRequest(bSwReq),
        .iDisableShiftIn(bDisIn), .iDisableShiftOut(bDisOut), .iDisableExec(bDisExec),
        .iReadAddress(bRdAddr), .iWriteAddress(bWrAddr),
        .oStateSwitchHalt(bHalt), .oBusy(bBusy), .oDone(bDone), .oError(bError),
        .iStateDataOut(bDataOut), .oStateDataIn(bDataIn), .oStateShift(bShift),
        .oStateNewIn(bNewIn), .oStateOldOut(bOldOut),
        .oStateMemReadRequest(bMemRd), .oStateMemWriteRequest(bMemWr),
        .oStateMemAddress(bMemAddr), .oStateMemWriteData(bMemWData),
        .iStateMemReadData(bMemRData), .iWriteAccept(bWrAccept), .iReadValid(bRdValid));

    int          nChecks = 0;
    int          nFails  = 0;
    int          shInCnt, shOutCnt, curWordSh, nRd, nWr, oldCnt, newCnt, doneCnt, haltCnt;
    int          viol, rdLat, stallCnt;
    logic        timedOut;
    logic [31:0] wrAddrs[4];
    logic [31:0] wrData[4];
    int          wrShifts[4];
    logic [31:0] rdAddrs[4];
    logic [31:0] rdMem[3];
    logic [31:0] rdHoldAddr;
    logic [69:0] recv, chainA;
    logic [63:0] chainB;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleA(input string tag);
        check({tag, " ctrl"}, {aHalt, aBusy, aDone, aError, aShift, aNewIn, aOldOut, aMemRd, aMemWr}, '0);
        check({tag, " addr"}, aMemAddr, '0);
        check({tag, " wdata"}, aMemWData, '0);
        check({tag, " datain"}, aDataIn, 2'b11);
    endtask

    task automatic clearStats();
        shInCnt = 0; shOutCnt = 0; curWordSh = 0; nRd = 0; nWr = 0;
        oldCnt = 0; newCnt = 0; doneCnt = 0; haltCnt = 0; viol = 0;
        rdLat = 0; stallCnt = 0; timedOut = 1'b0; recv = '0;
        for (int i = 0; i < 4; i++) begin
            wrAddrs[i] = '0; wrData[i] = '0; wrShifts[i] = 0; rdAddrs[i] = '0;
        end
    endtask

    // Reactive memory/chain model for instance A; returns after oDone or the cycle budget.
    task automatic runA(input bit hasIn, input int rdLatency, input int stallCycles,
                        input bit acceptWr, input int maxCycles);
        clearStats();
        aStall = 1'b0;
        for (int cyc = 0; cyc < maxCycles; cyc++) begin
            @(posedge iClk); #1;
            aWrAccept = 1'b0; aRdValid = 1'b0; aMemRData = '0;
            if (aShift && (aMemRd || aMemWr)) viol++;
            if (aOldOut) oldCnt++;
            if (aNewIn) newCnt++;
            if (aHalt) haltCnt++;
            if (aShift && hasIn && haltCnt == 0) begin
                if (shInCnt < 35) recv[shInCnt*2 +: 2] = aDataIn;
                shInCnt++;
            end else begin
                if (aDataIn !== 2'b11) viol++;
                if (aShift) begin
                    aDataOut = 2'(chainA >> (shOutCnt * 2));
                    shOutCnt++;
                    curWordSh++;
                end
            end
            if (aMemRd) begin
                if (rdLat == 0) rdHoldAddr = aMemAddr;
                else if (aMemAddr !== rdHoldAddr) viol++;
                rdLat++;
                if (rdLat >= rdLatency) begin
                    if (nRd < 3) begin
                        rdAddrs[nRd] = aMemAddr;
                        aMemRData = rdMem[nRd];
                    end
                    aRdValid = 1'b1;
                    nRd++;
                    rdLat = 0;
                end
            end
            if (aMemWr && !acceptWr) break;
            if (aMemWr) begin
                if (nWr < 4) begin
                    wrAddrs[nWr] = aMemAddr; wrData[nWr] = aMemWData; wrShifts[nWr] = curWordSh;
                end
                aWrAccept = 1'b1;
                nWr++;
                curWordSh = 0;
            end
            if (aHalt) begin
                if (stallCnt < stallCycles) begin
                    stallCnt++;
                    aStall = 1'b1;
                end else begin
                    aStall = 1'b0;
                end
            end
            if (aDone) begin
                doneCnt++;
                break;
            end
            if (cyc == maxCycles - 1) timedOut = 1'b1;
        end
        aWrAccept = 1'b0; aRdValid = 1'b0; aStall = 1'b0;
    endtask

    initial begin
        iReset = 1'b0;
        {aStall, aRdReq, aWrReq, aSwReq, aDisIn, aDisOut, aDisExec, aWrAccept, aRdValid} = '0;
        {bStall, bRdReq, bWrReq, bSwReq, bDisIn, bDisOut, bDisExec, bWrAccept, bRdValid} = '0;
        aRdAddr = 32'h0000_1000; aWrAddr = 32'h0000_2000;
        bRdAddr = 32'h0000_0000; bWrAddr = 32'hFFFF_FFFC;
        aDataOut = '0; bDataOut = '0; aMemRData = '0; bMemRData = '0;
        chainA = 70'h3A5C3E91F07B6D48AC;
        chainB = 64'h0123456789ABCDEF;
        rdMem[0] = 32'hDEADBEEF; rdMem[1] = 32'h01234567; rdMem[2] = 32'hFFFFFFE5;

        repeat (2) @(posedge iClk);
        #1;
        checkIdleA("reset A");
        check("reset B ctrl", {bHalt, bBusy, bDone, bError, bShift, bMemRd, bMemWr}, '0);
        check("reset B datain", bDataIn, 8'hFF);
        iReset = 1'b1;
        @(posedge iClk); #1;

        // Save: 16+16+3 shifts, writes at W, W+4, W+8, last word zero-padded
        aRdReq = 1'b1;
        runA(1'b0, 1, 0, 1'b1, 300);
        aRdReq = 1'b0;
        check("save timeout", timedOut, 1'b0);
        check("save oldout pulses", oldCnt, 1);
        check("save newin pulses", newCnt, 0);
        check("save writes", nWr, 3);
        check("save shifts w0", wrShifts[0], 16);
        check("save shifts w1", wrShifts[1], 16);
        check("save shifts w2", wrShifts[2], 3);
        check("save addr w0", wrAddrs[0], 32'h0000_2000);
        check("save addr w1", wrAddrs[1], 32'h0000_2004);
        check("save addr w2", wrAddrs[2], 32'h0000_2008);
        check("save data w0", wrData[0], 32'h7B6D48AC);
        check("save data w1", wrData[1], 32'h5C3E91F0);
        check("save data w2", wrData[2], 32'h0000003A);
        check("save halt cycles", haltCnt, 0);
        check("save done", doneCnt, 1);
        check("save protocol", viol, 0);
        @(posedge iClk); #1;
        check("save done one cycle", aDone, 1'b0);

        // Restore: 5-cycle read latency, 4 stall cycles in WAITMEM
        aWrReq = 1'b1;
        runA(1'b1, 5, 4, 1'b1, 400);
        aWrReq = 1'b0;
        check("restore timeout", timedOut, 1'b0);
        check("restore reads", nRd, 3);
        check("restore addr r0", rdAddrs[0], 32'h0000_1000);
        check("restore addr r1", rdAddrs[1], 32'h0000_1004);
        check("restore addr r2", rdAddrs[2], 32'h0000_1008);
        check("restore shifts", shInCnt, 35);
        check("restore chain bits", recv, 70'h25_01234567_DEADBEEF);
        check("restore halt cycles", haltCnt, 6);
        check("restore newin pulses", newCnt, 1);
        check("restore oldout pulses", oldCnt, 0);
        check("restore writes", nWr, 0);
        check("restore done", doneCnt, 1);
        check("restore protocol", viol, 0);
        @(posedge iClk); #1;

        // Swap with execution pulses suppressed, zero-wait memory
        aSwReq = 1'b1; aDisExec = 1'b1;
        runA(1'b1, 1, 0, 1'b1, 400);
        aSwReq = 1'b0; aDisExec = 1'b0;
        check("swap timeout", timedOut, 1'b0);
        check("swap exec pulses", {oldCnt, newCnt}, '0);
        check("swap in shifts", shInCnt, 35);
        check("swap out shifts", shOutCnt, 35);
        check("swap reads", nRd, 3);
        check("swap writes", nWr, 3);
        check("swap addr w2", wrAddrs[2], 32'h0000_2008);
        check("swap data w1", wrData[1], 32'h5C3E91F0);
        check("swap done", doneCnt, 1);
        check("swap protocol", viol, 0);
        @(posedge iClk); #1;

        // Two requests rising together are rejected
        aRdReq = 1'b1; aWrReq = 1'b1;
        @(posedge iClk); #1;
        check("dual req error", aError, 1'b1);
        check("dual req busy", aBusy, 1'b0);
        @(posedge iClk); #1;
        check("dual req error pulse", aError, 1'b0);
        check("dual req idle", {aBusy, aMemRd, aMemWr, aShift}, '0);
        aRdReq = 1'b0; aWrReq = 1'b0;
        @(posedge iClk); #1;

        // Reset while a save write is pending, then a fresh save
        aRdReq = 1'b1;
        runA(1'b0, 1, 0, 1'b0, 200);
        check("abort write pending", aMemWr, 1'b1);
        #2 iReset = 1'b0;
        @(posedge iClk); #1;
        checkIdleA("abort reset");
        aRdReq = 1'b0;
        iReset = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        check("abort stays idle", {aBusy, aMemRd, aMemWr}, '0);
        aRdReq = 1'b1;
        runA(1'b0, 1, 0, 1'b1, 300);
        aRdReq = 1'b0;
        check("resave timeout", timedOut, 1'b0);
        check("resave writes", nWr, 3);
        check("resave data w0", wrData[0], 32'h7B6D48AC);
        check("resave done", doneCnt, 1);
        @(posedge iClk); #1;

        // Byte lanes and write-address wrap on instance B
        clearStats();
        bRdReq = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge iClk); #1;
            bWrAccept = 1'b0;
            if (bShift) begin
                bDataOut = 8'(chainB >> (shOutCnt * 8));
                shOutCnt++;
                curWordSh++;
            end
            if (bMemWr) begin
                if (nWr < 4) begin
                    wrAddrs[nWr] = bMemAddr; wrData[nWr] = bMemWData; wrShifts[nWr] = curWordSh;
                end
                bWrAccept = 1'b1;
                nWr++;
                curWordSh = 0;
            end
            if (bDone) begin
                doneCnt++;
                break;
            end
            if (cyc == 99) timedOut = 1'b1;
        end
        bRdReq = 1'b0; bWrAccept = 1'b0;
        check("wide timeout", timedOut, 1'b0);
        check("wide writes", nWr, 2);
        check("wide shifts w0", wrShifts[0], 4);
        check("wide shifts w1", wrShifts[1], 4);
        check("wide addr w0", wrAddrs[0], 32'hFFFF_FFFC);
        check("wide addr wrap", wrAddrs[1], 32'h0000_0000);
        check("wide data w0", wrData[0], 32'h89ABCDEF);
        check("wide data w1", wrData[1], 32'h01234567);
        check("wide done", doneCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
